zsram_access_controller: RTL and testbench
==========================================

# zsram_access_controller

Sequencer and two-port arbiter for a word-organised array of zero-second RAM cells. It grants one of two requesters at a time using round-robin arbitration. For each granted request it drives the shared array address and write data, then generates non-overlapping WriteEdge/ReadEdge strobes with setup and hold phases. It sits between the bit-cell array and the logic that uses the array, and is the only block allowed to drive the array's edge lines.

## Interface
Parameters:
- ADDR_WIDTH, 4: word address width.
- DATA_WIDTH, 8: word width; one cell per bit.
- STROBE_CYCLES, 2: cycles each edge strobe stays high; legal range ≥1.

Ports:
- Clock  in  1  single clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high.
- ReqA / ReqB  in  1  access request.
- WeA / WeB  in  1  1 = write, 0 = read.
- AddrA / AddrB  in  ADDR_WIDTH  word address.
- WDataA / WDataB  in  DATA_WIDTH  write data.
- GntA / GntB  out  1  one-cycle pulse: request accepted and latched.
- DoneA / DoneB  out  1  one-cycle pulse: transaction complete.
- RData  out  DATA_WIDTH  last captured read word; shared by both requesters.
- ArrayAddr  out  ADDR_WIDTH  word select to the array.
- ArrayWData  out  DATA_WIDTH  drives cell inputData.
- ArrayRData  in  DATA_WIDTH  from cell outputData.
- WriteEdge / ReadEdge  out  1  cell strobes.
- VerifyError  out  1  write-verify mismatch pulse (see Configuration).

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, plus VSTROBE and VHOLD when verify is compiled in.
- IDLE:
  - Samples ReqA and ReqB. Requests are sampled only in IDLE and are ignored while busy.
  - If any request is high, latches the winner's We, Addr and WData, then moves to SETUP.
- Arbitration:
  - A single priority pointer selects the winner when both requesters ask at once.
  - After each grant, the pointer moves to the other requester.
  - Reset sets the pointer to A.
  - A lone requester always wins.
- SETUP, 1 cycle:
  - Gnt pulses for the winner.
  - ArrayAddr and ArrayWData are driven from the latched values.
  - Both edges stay low.
- STROBE, STROBE_CYCLES cycles:
  - WriteEdge is high for a write; ReadEdge is high for a read.
  - A down-counter loaded with STROBE_CYCLES−1 times this phase.
- HOLD, 1 cycle:
  - Both edges are low; address and data stay stable.
  - Done pulses for the winner.
  - Next state is IDLE.
- Read capture: ArrayRData is registered into RData on the edge that ends the last STROBE cycle. RData holds until the next read capture. Writes never change RData.
- WriteEdge and ReadEdge are never high in the same cycle. At least one edge-low cycle always separates consecutive strobes.
- Outside SETUP through HOLD, ArrayAddr and ArrayWData keep their last value.
- Reset values:
  - State is IDLE.
  - All Gnt, Done, WriteEdge, ReadEdge and VerifyError outputs are 0.
  - RData, ArrayAddr and ArrayWData are 0.
  - Priority pointer is A.
- Reset mid-transaction: edges drop asynchronously and no Done is issued. The interrupted request is lost; the requester must re-request.

## Timing
- Let E0 be the edge where IDLE samples a request. Cycle numbers below count from the cycle after E0 (cycle 1).
- Gnt is high in cycle 1 (SETUP).
- The edge strobe is high in cycles 2 through STROBE_CYCLES+1.
- Done is high in cycle STROBE_CYCLES+2.
- The controller is back in IDLE in cycle STROBE_CYCLES+3.
- Throughput is one transaction per STROBE_CYCLES+3 cycles.
- Requester rules:
  - Hold Req, We, Addr and WData stable until Gnt is seen.
  - Deassert Req in the cycle after Gnt unless a new request is intended.
  - Req still high in the following IDLE is treated as a new request.
- RData is valid in the Done cycle and holds afterwards.

## Configuration
- ZSRAM_WRITE_VERIFY_EN defined:
  - A write does not finish at HOLD. Instead it continues HOLD → VSTROBE (ReadEdge high for STROBE_CYCLES) → VHOLD.
  - The read-back word is compared with the latched write data at the end of VSTROBE.
  - Done pulses in VHOLD, and VerifyError pulses in the same cycle on mismatch.
  - RData is not updated by the verify read.
  - Write latency grows by STROBE_CYCLES+1.
- Not defined: VSTROBE and VHOLD are absent and VerifyError is tied to 0.

## Test plan
- Reset, then write A at Addr 3 with 0xA5 (STROBE_CYCLES=2):
  - GntA in cycle 1; WriteEdge in cycles 2–3 with ArrayAddr=3 and ArrayWData=0xA5.
  - DoneA in cycle 4; ReadEdge stays 0 throughout.
- Read B at Addr 3 with an array model holding 0xA5 → ReadEdge in cycles 2–3, DoneB in cycle 4, RData=0xA5 from cycle 4 on.
- ReqA and ReqB asserted in the same cycle, held high → grants alternate A, B, A, B (5 cycles apart); no edge overlap; at least one edge-low cycle between strobes.
- Assert Reset during the 2nd STROBE cycle of a write:
  - WriteEdge is 0 immediately; no Done.
  - After release, all outputs are at reset values and the pointer is A.
- STROBE_CYCLES=1, back-to-back reads from A → Done every 4 cycles; RData updates each transaction.
- With ZSRAM_WRITE_VERIFY_EN, write 0x3C to a model stuck at 0x38 → ReadEdge in cycles 5–6, then DoneA and VerifyError=1 in cycle 7. With matching data, VerifyError stays 0.

Source files
------------

// File: rtl/zsram_access_controller.sv
// Round-robin two-port sequencer driving WriteEdge/ReadEdge strobes of a zero-second RAM array.
// Define ZSRAM_WRITE_VERIFY_EN to add a read-back verify after every write.
module zsram_access_controller #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ReqA,
  input  logic                  ReqB,
  input  logic                  WeA,
  input  logic                  WeB,
  input  logic [ADDR_WIDTH-1:0] AddrA,
  input  logic [ADDR_WIDTH-1:0] AddrB,
  input  logic [DATA_WIDTH-1:0] WDataA,
  input  logic [DATA_WIDTH-1:0] WDataB,
  output logic                  GntA,
  output logic                  GntB,
  output logic                  DoneA,
  output logic                  DoneB,
  output logic [DATA_WIDTH-1:0] RData,
  output logic [ADDR_WIDTH-1:0] ArrayAddr,
  output logic [DATA_WIDTH-1:0] ArrayWData,
  input  logic [DATA_WIDTH-1:0] ArrayRData,
  output logic                  WriteEdge,
  output logic                  ReadEdge,
  output logic                  VerifyError
);

  localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
`ifdef ZSRAM_WRITE_VERIFY_EN
    HOLD,
    VSTROBE,
    VHOLD
`else
    HOLD
`endif
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            ptr;
  logic            owner;
  logic            lat_we;
  logic [CW-1:0]   cnt;
  logic            cnt_zero;
  logic            req_any;
  logic            take_b;
  logic            done;
  logic            load_cnt;

  assign req_any  = ReqA | ReqB;
  // B wins when alone, or when both ask and the pointer favours B
  assign take_b   = ReqB & (~ReqA | ptr);
  assign cnt_zero = (cnt == '0);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  if (cnt_zero) state_nxt = HOLD;
`ifdef ZSRAM_WRITE_VERIFY_EN
      HOLD:    state_nxt = lat_we ? VSTROBE : IDLE;
      VSTROBE: if (cnt_zero) state_nxt = VHOLD;
      VHOLD:   state_nxt = IDLE;
`else
      HOLD:    state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ZSRAM_WRITE_VERIFY_EN
  logic vmis;

  assign load_cnt    = (state == SETUP) | (state == HOLD);
  assign done        = ((state == HOLD) & ~lat_we) | (state == VHOLD);
  assign ReadEdge    = ((state == STROBE) & ~lat_we) | (state == VSTROBE);
  assign VerifyError = (state == VHOLD) & vmis;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      vmis <= 1'b0;
    else if (state == VSTROBE && cnt_zero)
      vmis <= (ArrayRData != ArrayWData);
  end
`else
  assign load_cnt    = (state == SETUP);
  assign done        = (state == HOLD);
  assign ReadEdge    = (state == STROBE) & ~lat_we;
  assign VerifyError = 1'b0;
`endif

  assign WriteEdge = (state == STROBE) & lat_we;
  assign GntA      = (state == SETUP) & ~owner;
  assign GntB      = (state == SETUP) & owner;
  assign DoneA     = done & ~owner;
  assign DoneB     = done & owner;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ptr        <= 1'b0;
      owner      <= 1'b0;
      lat_we     <= 1'b0;
      cnt        <= '0;
      ArrayAddr  <= '0;
      ArrayWData <= '0;
      RData      <= '0;
    end else begin
      if (state == IDLE && req_any) begin
        owner      <= take_b;
        ptr        <= ~take_b;
        lat_we     <= take_b ? WeB : WeA;
        ArrayAddr  <= take_b ? AddrB : AddrA;
        ArrayWData <= take_b ? WDataB : WDataA;
      end
      if (load_cnt)
        cnt <= CNT_LOAD;
      else if (!cnt_zero)
        cnt <= cnt - 1'b1;
      if (state == STROBE && cnt_zero && !lat_we)
        RData <= ArrayRData;
    end
  end

endmodule

// File: tb/tb_zsram_access_controller.sv
// Directed bench for zsram_access_controller: STROBE_CYCLES=2 main instance, =1 read instance.
// Verify-path vectors run only when ZSRAM_WRITE_VERIFY_EN is defined.
`timescale 1ns/1ps
module tb_zsram_access_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 0, req_b = 0, we_a = 0, we_b = 0;
  logic [3:0] addr_a = 0, addr_b = 0;
  logic [7:0] wdata_a = 0, wdata_b = 0;
  logic       gnt_a, gnt_b, done_a, done_b;
  logic [7:0] rdata, arr_wdata, arr_rdata;
  logic [3:0] arr_addr;
  logic       wr_edge, rd_edge, verr;
  logic       stuck = 1'b0;
  logic [7:0] mem [16];

  logic       req1 = 0;
  logic       zero1 = 0;
  logic [3:0] addr1 = 4'd9;
  logic [7:0] wd1 = 8'h00;
  logic       gnt_a1, gnt_b1, done_a1, done_b1;
  logic [7:0] rdata1, arr_wdata1, arr_rdata1;
  logic [3:0] arr_addr1;
  logic       wr_edge1, rd_edge1, verr1;
  logic [7:0] n1;

  int checks = 0;
  int failures = 0;
  logic prev_w, prev_r;

  always #5 clk = ~clk;

  zsram_access_controller #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .STROBE_CYCLES(2)
  ) dut (
    .Clock(clk), .Reset(rst),
    .ReqA(req_a), .ReqB(req_b), .WeA(we_a), .WeB(we_b),
    .AddrA(addr_a), .AddrB(addr_b), .WDataA(wdata_a), .WDataB(wdata_b),
    .GntA(gnt_a), .GntB(gnt_b), .DoneA(done_a), .DoneB(done_b),
    .RData(rdata), .ArrayAddr(arr_addr), .ArrayWData(arr_wdata),
    .ArrayRData(arr_rdata), .WriteEdge(wr_edge), .ReadEdge(rd_edge),
    .VerifyError(verr)
  );

  zsram_access_controller #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .STROBE_CYCLES(1)
  ) dut1 (
    .Clock(clk), .Reset(rst),
    .ReqA(req1), .ReqB(zero1), .WeA(zero1), .WeB(zero1),
    .AddrA(addr1), .AddrB(addr1), .WDataA(wd1), .WDataB(wd1),
    .GntA(gnt_a1), .GntB(gnt_b1), .DoneA(done_a1), .DoneB(done_b1),
    .RData(rdata1), .ArrayAddr(arr_addr1), .ArrayWData(arr_wdata1),
    .ArrayRData(arr_rdata1), .WriteEdge(wr_edge1), .ReadEdge(rd_edge1),
    .VerifyError(verr1)
  );

  // array models
  always_ff @(posedge clk) if (wr_edge) mem[arr_addr] <= arr_wdata;
  assign arr_rdata = stuck ? 8'h38 : mem[arr_addr];

  always_ff @(posedge clk or posedge rst)
    if (rst) n1 <= 8'd0;
    else if (done_a1) n1 <= n1 + 8'd1;
  assign arr_rdata1 = 8'h40 + n1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", {30'd0, gnt_a, gnt_b}, 0);
    check("rst_done", {30'd0, done_a, done_b}, 0);
    check("rst_edges", {29'd0, wr_edge, rd_edge, verr}, 0);
    check("rst_rdata", {24'd0, rdata}, 0);
    check("rst_addr", {28'd0, arr_addr}, 0);
    check("rst_wdata", {24'd0, arr_wdata}, 0);
    rst = 1'b0;
    tick();

    // write A: addr 3, 0xA5
    req_a = 1; we_a = 1; addr_a = 4'd3; wdata_a = 8'hA5;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 1) req_a = 0;
      check("wr_gnt_a", {31'd0, gnt_a}, {31'd0, i == 1});
      check("wr_we", {31'd0, wr_edge}, {31'd0, i == 2 || i == 3});
      check("wr_re", {31'd0, rd_edge}, 0);
      check("wr_done_a", {31'd0, done_a}, {31'd0, i == 4});
      if (i == 2 || i == 3) begin
        check("wr_addr", {28'd0, arr_addr}, 3);
        check("wr_data", {24'd0, arr_wdata}, 32'hA5);
      end
    end

    // read B: addr 3
    req_b = 1; we_b = 0; addr_b = 4'd3;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 1) req_b = 0;
      check("rd_gnt_b", {31'd0, gnt_b}, {31'd0, i == 1});
      check("rd_re", {31'd0, rd_edge}, {31'd0, i == 2 || i == 3});
      check("rd_we", {31'd0, wr_edge}, 0);
      check("rd_done_b", {31'd0, done_b}, {31'd0, i == 4});
      if (i >= 4) check("rd_rdata", {24'd0, rdata}, 32'hA5);
    end

    // both held: A, B, A, B five cycles apart
    req_a = 1; we_a = 1; addr_a = 4'd7; wdata_a = 8'h11;
    req_b = 1; we_b = 0; addr_b = 4'd3;
    prev_w = 0; prev_r = 0;
    for (int i = 1; i <= 19; i++) begin
      tick();
      check("alt_gnt_a", {31'd0, gnt_a}, {31'd0, i == 1 || i == 11});
      check("alt_gnt_b", {31'd0, gnt_b}, {31'd0, i == 6 || i == 16});
      check("alt_overlap", {31'd0, wr_edge & rd_edge}, 0);
      check("alt_gap", {31'd0, (wr_edge & prev_r) | (rd_edge & prev_w)}, 0);
      prev_w = wr_edge;
      prev_r = rd_edge;
    end
    req_a = 0; req_b = 0;
    tick(); tick();

    // reset in the 2nd strobe cycle of a write
    req_a = 1; we_a = 1; addr_a = 4'd5; wdata_a = 8'h5A;
    tick();
    req_a = 0;
    tick(); tick();
    check("mid_we_before", {31'd0, wr_edge}, 1);
    rst = 1'b1;
    #1;
    check("mid_we_drop", {31'd0, wr_edge}, 0);
    check("mid_done", {31'd0, done_a}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("post_done", {30'd0, done_a, done_b}, 0);
      check("post_edges", {30'd0, wr_edge, rd_edge}, 0);
    end
    check("post_addr", {28'd0, arr_addr}, 0);
    check("post_wdata", {24'd0, arr_wdata}, 0);
    check("post_rdata", {24'd0, rdata}, 0);
    req_a = 1; we_a = 0; addr_a = 4'd3;
    req_b = 1; we_b = 0; addr_b = 4'd3;
    tick();
    check("ptr_gnt_a", {31'd0, gnt_a}, 1);
    check("ptr_gnt_b", {31'd0, gnt_b}, 0);
    req_a = 0; req_b = 0;
    repeat (5) tick();
    check("ptr_rdata", {24'd0, rdata}, 32'hA5);

    // STROBE_CYCLES=1, back-to-back reads from A
    req1 = 1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      check("sc1_gnt", {31'd0, gnt_a1}, {31'd0, (i % 4) == 1});
      check("sc1_re", {31'd0, rd_edge1}, {31'd0, (i % 4) == 2});
      check("sc1_done", {31'd0, done_a1}, {31'd0, (i % 4) == 3});
      if ((i % 4) == 3) check("sc1_rdata", {24'd0, rdata1}, 32'h40 + i / 4);
      if (i == 11) req1 = 0;
    end
    tick();

`ifdef ZSRAM_WRITE_VERIFY_EN
    for (int t = 0; t < 2; t++) begin
      stuck = (t == 0);
      req_a = 1; we_a = 1; addr_a = 4'd2; wdata_a = 8'h3C;
      for (int i = 1; i <= 8; i++) begin
        tick();
        if (i == 1) req_a = 0;
        check("v_we", {31'd0, wr_edge}, {31'd0, i == 2 || i == 3});
        check("v_re", {31'd0, rd_edge}, {31'd0, i == 5 || i == 6});
        check("v_done", {31'd0, done_a}, {31'd0, i == 7});
        check("v_err", {31'd0, verr}, {31'd0, i == 7 && t == 0});
      end
      check("v_rdata", {24'd0, rdata}, 32'hA5);
    end
    stuck = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
